// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared skid-buffer types and push/pop operation encoding
package fifo_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } skid_op_e;

  function automatic skid_op_e skid_op(input logic push, input logic pop);
    return skid_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/fifo_stream_adapter_if.sv
// rtl/fifo_stream_adapter_if.sv - valid/ready stream toward the next pipeline stage
interface fifo_stream_adapter_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - two-entry in-order shift buffer; head is always the oldest word
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head
);

  occ_t                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (skid_op(push, pop))
      OP_PUSH: begin
        if (occ_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      OP_POP: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      OP_BOTH: begin
        // Occupancy is unchanged; the incoming word lands behind whatever survives the pop.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data;
        end else begin
          head_d = push_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign occ  = occ_q;
  assign head = head_q;

endmodule

// File: rtl/fifo_stream_adapter.sv
// rtl/fifo_stream_adapter.sv - drains a registered-output FIFO into a valid/ready stream
module fifo_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  fifo_stream_adapter_if.master m_if,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  idle
);

  occ_t                 occ;
  logic                 pop;
  logic                 push;
  logic [2:0]           fill_after_pop;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (fifo_data),
    .occ       (occ),
    .head      (m_if.m_data)
  );

  assign m_if.m_valid = (occ != 2'd0);
  assign pop          = m_if.m_valid & m_if.m_ready;
  assign push         = pend_q;

  // Counting the in-flight read and crediting this cycle's pop keeps full throughput without overflow.
  assign fill_after_pop = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
  assign fifo_r_en      = rst_n & drain_en & ~fifo_empty & (fill_after_pop < 3'd2);

  always_comb begin
    pend_d = fifo_r_en;
    cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign words_out = cnt_q;
  assign idle      = (occ == 2'd0) & ~pend_q & fifo_empty;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !((skid_op(push, pop) == OP_PUSH) && (occ == occ_t'(SKID_DEPTH))));

  a_no_read_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_r_en && fifo_empty));

  a_stream_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_if.m_valid && !m_if.m_ready) |=> (m_if.m_valid && $stable(m_if.m_data)));

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb/tb_fifo_stream_adapter.sv - randomized self-checking bench with a queue-based reference model
module tb_fifo_stream_adapter;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          drain_en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_r_en;
  logic [CW-1:0] words_out;
  logic          idle;

  fifo_stream_adapter_if #(.DATA_WIDTH(DW)) sif ();

  fifo_stream_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drain_en   (drain_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_if       (sif),
    .words_out  (words_out),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: words still inside the FIFO, words owed to the stream, cycle of each unpopped read.
  byte unsigned fifo_q[$];
  byte unsigned exp_q[$];
  int           iss_q[$];
  int           cyc = 0;
  int           n_pop = 0;
  int           n_rd = 0;
  int           first_rd = -1;
  int           log_cyc[$];
  byte unsigned log_dat[$];
  logic         s_ren = 1'b0;
  logic         s_pop = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_word(input byte unsigned w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    iss_q.delete();
    n_pop = 0;
    fifo_data = '0;
    fifo_empty = 1'b1;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_dat.delete();
    n_rd = 0;
    first_rd = -1;
  endtask

  // One clock: check outputs at negedge, then advance the FIFO and the model after the posedge.
  task automatic step();
    logic e_valid, e_pop, e_ren, e_idle;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_r_en", int'(fifo_r_en), 0);
      chk("rst_m_valid", int'(sif.m_valid), 0);
      s_ren = 1'b0;
      s_pop = 1'b0;
    end else begin
      e_valid = (iss_q.size() > 0) && (iss_q[0] <= cyc - 2);
      e_pop   = e_valid && sif.m_ready;
      e_ren   = drain_en && (fifo_q.size() > 0) && ((iss_q.size() - int'(e_pop)) < 2);
      e_idle  = (iss_q.size() == 0) && (fifo_q.size() == 0);
      chk("m_valid", int'(sif.m_valid), int'(e_valid));
      chk("fifo_r_en", int'(fifo_r_en), int'(e_ren));
      chk("words_out", int'(words_out), n_pop % (1 << CW));
      chk("idle", int'(idle), int'(e_idle));
      if (e_valid) chk("m_data", int'(sif.m_data), int'(exp_q[0]));
      s_ren = e_ren;
      s_pop = e_pop;
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (s_pop) begin
        log_cyc.push_back(cyc);
        log_dat.push_back(exp_q[0]);
        void'(exp_q.pop_front());
        void'(iss_q.pop_front());
        n_pop++;
      end
      if (s_ren) begin
        iss_q.push_back(cyc);
        fifo_data = fifo_q.pop_front();
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
      end
      fifo_empty = (fifo_q.size() == 0);
    end
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0 || iss_q.size() != 0) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, guard, bad;
    sif.m_ready = 1'b0;

    // Reset values
    step();
    step();
    chk("reset_m_valid", int'(sif.m_valid), 0);
    chk("reset_m_data", int'(sif.m_data), 0);
    chk("reset_words_out", int'(words_out), 0);
    chk("reset_r_en", int'(fifo_r_en), 0);
    chk("reset_idle_empty", int'(idle), 1);
    fifo_empty = 1'b0;
    #1;
    chk("reset_idle_nonempty", int'(idle), 0);
    fifo_empty = 1'b1;
    rst_n = 1'b1;

    // Basic latency
    clear_log();
    sif.m_ready = 1'b1;
    drain_en = 1'b1;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    run_until_idle(20);
    chk("basic_n", log_dat.size(), 3);
    if (log_dat.size() == 3) begin
      chk("basic_lat0", log_cyc[0] - first_rd, 2);
      chk("basic_lat1", log_cyc[1] - first_rd, 3);
      chk("basic_lat2", log_cyc[2] - first_rd, 4);
      chk("basic_d0", int'(log_dat[0]), 'h11);
      chk("basic_d1", int'(log_dat[1]), 'h22);
      chk("basic_d2", int'(log_dat[2]), 'h33);
    end
    chk("basic_words", int'(words_out), 3);
    chk("basic_idle", int'(idle), 1);

    // Stall and refill
    clear_log();
    sif.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(byte'(8'h40 + i));
    repeat (10) step();
    chk("stall_reads", n_rd, 2);
    chk("stall_valid", int'(sif.m_valid), 1);
    chk("stall_head", int'(sif.m_data), 'h40);
    sif.m_ready = 1'b1;
    run_until_idle(40);
    chk("stall_n", log_dat.size(), 8);
    for (int i = 0; i < 8 && i < log_dat.size(); i++)
      chk("stall_order", int'(log_dat[i]), 'h40 + i);
    chk("stall_words", int'(words_out), 11);

    // drain_en deassert right after a read
    clear_log();
    for (int i = 0; i < 4; i++) push_word(byte'(8'h50 + i));
    guard = 0;
    do begin
      step();
      guard++;
    end while (!s_ren && guard < 5);
    chk("drain_first_read", int'(s_ren), 1);
    drain_en = 1'b0;
    n_rd = 0;
    repeat (6) step();
    chk("drain_no_reads", n_rd, 0);
    chk("drain_landed_n", log_dat.size(), 1);
    if (log_dat.size() > 0) chk("drain_landed_d", int'(log_dat[0]), 'h50);
    drain_en = 1'b1;
    run_until_idle(30);
    chk("drain_words", int'(words_out), 15);

    // Random backpressure, 200 words
    clear_log();
    pushed = 0;
    guard = 0;
    while ((pushed < 200 || exp_q.size() != 0 || iss_q.size() != 0) && guard < 5000) begin
      if (pushed < 200 && $urandom_range(0, 2) != 0) begin
        push_word(byte'((pushed * 7 + 3) & 8'hff));
        pushed++;
      end
      sif.m_ready = 1'($urandom_range(0, 1));
      drain_en = ($urandom_range(0, 7) != 0);
      step();
      guard++;
    end
    chk("rand_done", int'(exp_q.size() == 0 && iss_q.size() == 0), 1);
    bad = 0;
    for (int i = 0; i < log_dat.size(); i++)
      if (int'(log_dat[i]) != ((i * 7 + 3) & 'hff)) bad++;
    chk("rand_n", log_dat.size(), 200);
    chk("rand_order_errors", bad, 0);
    chk("rand_words", int'(words_out), (15 + 200) % 16);

    // Reset mid-stream
    drain_en = 1'b1;
    sif.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(byte'(8'h90 + i));
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", int'(sif.m_valid), 0);
    chk("midrst_words", int'(words_out), 0);
    chk("midrst_r_en", int'(fifo_r_en), 0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;

    // Counter wrap with a 4-bit counter
    clear_log();
    sif.m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(byte'(8'hc0 + i));
    run_until_idle(60);
    chk("wrap_n", log_dat.size(), 17);
    chk("wrap_words", int'(words_out), 1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_stream_adapter.md
# fifo_stream_adapter

Downstream drain stage for the synchronous FIFO. It watches the FIFO `empty` flag, issues `r_en` pulses, and captures the FIFO's registered `data_out` one cycle later into a 2-entry skid buffer. The buffer drives a valid/ready stream master toward the next pipeline stage. The block sustains one word per cycle with zero loss or duplication under arbitrary backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width; must match the FIFO's `DATA_WIDTH`.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

Ports:
- `clk`: input, 1 bit. Single clock, shared with the FIFO.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `drain_en`: input, 1 bit. Permits issuing new FIFO reads.
- `fifo_empty`: input, 1 bit. FIFO `empty` flag.
- `fifo_data`: input, `DATA_WIDTH` bits. FIFO registered `data_out`.
- `fifo_r_en`: output, 1 bit. FIFO read enable.
- `m_valid`: output, 1 bit. Stream word available.
- `m_ready`: input, 1 bit. Downstream accepts.
- `m_data`: output, `DATA_WIDTH` bits. Stream word (head of skid buffer).
- `words_out`: output, `CNT_WIDTH` bits. Count of accepted stream beats.
- `idle`: output, 1 bit. Nothing buffered, nothing in flight, FIFO empty.

## Operation
- **State**
  - `occ`: skid occupancy, 0..2.
  - `pend`: 1 bit, a read was issued last cycle and its data is on `fifo_data` this cycle.
  - Two data slots `head` and `tail`.
- **Pop**: `pop = m_valid & m_ready`. `m_valid = (occ != 0)`. `m_data = head`.
- **Read issue**: `fifo_r_en = drain_en & !fifo_empty & ((occ + pend - pop) < 2)`.
  - This is a combinational path from `m_ready` to `fifo_r_en`; it is required for full throughput.
  - `fifo_r_en` is never asserted while `fifo_empty` is high, so every issued read returns data.
- **Edge update**:
  - `pend <= fifo_r_en`.
  - If `pend`, `fifo_data` is pushed into the buffer.
  - Push and pop in the same cycle are both honoured:
    - `occ` is unchanged.
    - With `occ==1`: `head <= fifo_data`.
    - With `occ==2`: `head <= tail`, `tail <= fifo_data`.
  - Push alone writes to `head` when `occ==0`, otherwise to `tail`.
  - Pop alone shifts `tail` into `head`.
- **Overflow**: `occ + pend` never exceeds 2 by construction. Push while `occ==2` without a pop is illegal and must be assertion-checked.
- **drain_en low**: no new reads. An in-flight read still lands. Buffered words still drain to the stream.
- **words_out**: increments by 1 on each `pop`; wraps modulo `2^CNT_WIDTH`.
- **idle**: `(occ==0) & !pend & fifo_empty`.
- **Ordering**: words leave on `m_data` in FIFO order. No word is dropped or duplicated.
- **Stream protocol**: once `m_valid` is high, `m_valid` and `m_data` hold stable until `pop`.

## Timing
- **Reset values**:
  - `occ=0`, `pend=0`, `head=tail=0`, `words_out=0`.
  - Hence `m_valid=0`, `m_data=0`.
  - `fifo_r_en` is forced to 0 while `rst_n` is low.
  - `idle` follows `fifo_empty`.
- **Latency**: `fifo_r_en` high in cycle N → data on `fifo_data` in N+1 → `m_valid` high in N+2.
- **Throughput**: with `m_ready` held high, one word per cycle from N+2 onward while the FIFO is non-empty.
- **Backpressure**:
  - `m_ready` low with `occ==2` → `fifo_r_en` low the same cycle.
  - The first `m_ready` high cycle re-enables issue in that same cycle.
- **Reset mid-operation**: buffered and in-flight words are discarded. The FIFO is reset by the same `rst_n`, so the two remain consistent.

## Structure
- **Shared package `fifo_pkg`**:
  - `localparam SKID_DEPTH = 2`.
  - `typedef logic [1:0] occ_t`.
  - The `pop`/`push` encoding used by the assertions.
- **Sub-module `skid_buf2`**: 2-entry shift buffer with push/pop/`occ`, instantiated once.
- **Top level**: read-issue logic, `pend` flag, counter, `idle`, and assertions:
  - no overflow;
  - no read while empty;
  - `m_data` stable while `m_valid & !m_ready`.

## Test plan
- **Basic latency**: reset, write 0x11, 0x22, 0x33 into the FIFO, `m_ready=1`, `drain_en=1` → `m_data` shows 0x11, 0x22, 0x33 on three consecutive cycles starting 2 cycles after the first `fifo_r_en`; `words_out=3`; then `idle=1`.
- **Stall and refill**: hold `m_ready=0` with 8 words queued → exactly two reads issued; `occ=2`; `m_data=` first word, stable. Release `m_ready` → all 8 words delivered in order; `words_out=8`.
- **Random backpressure**: random `m_ready` (50%), 200 sequential words → output sequence equals input sequence; overflow assertion never fires.
- **drain_en deassert**: deassert `drain_en` the cycle after a `fifo_r_en` → that word still appears on `m_data`; no further reads until `drain_en=1`.
- **Counter wrap and reset**:
  - With `CNT_WIDTH=4`, deliver 17 words → `words_out=1`.
  - Assert `rst_n` low mid-stream → `m_valid=0`, `words_out=0`, `fifo_r_en=0` immediately.
